// File: rtl/multiword_add_seq_if.sv
// Request/result bundle for multiword_add_seq: operand request handshake in,
// sum/flags result handshake out. The slave modport is the adder's side.
interface multiword_add_seq_if #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
);
    localparam int N = WIDTH * WORDS;

    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         i_cin;
    logic         i_sub;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_s;
    logic         o_cout;
    logic         o_ovf;
    logic         o_zero;

    modport master (
        output i_valid, i_a, i_b, i_cin, i_sub, i_ready,
        input  o_ready, o_valid, o_s, o_cout, o_ovf, o_zero
    );

    modport slave (
        input  i_valid, i_a, i_b, i_cin, i_sub, i_ready,
        output o_ready, o_valid, o_s, o_cout, o_ovf, o_zero
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Sequential N-bit add/subtract, one WIDTH-bit carry-select chunk per cycle, LSB first.
// Define MULTIWORD_ADD_SEQ_FLAGS_EN to build the signed-overflow and zero flags.

module multiword_add_seq_csel #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    localparam int H  = W / 2;
    localparam int HW = W - H;

    logic [H:0]  lo;
    logic [HW:0] hi0;
    logic [HW:0] hi1;

    // Upper half is precomputed for both possible carries and picked by the lower half.
    assign lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + (H+1)'(cin);
    assign hi0 = {1'b0, a[W-1:H]} + {1'b0, b[W-1:H]};
    assign hi1 = {1'b0, a[W-1:H]} + {1'b0, b[W-1:H]} + (HW+1)'(1);

    assign s    = lo[H] ? {hi1[HW-1:0], lo[H-1:0]} : {hi0[HW-1:0], lo[H-1:0]};
    assign cout = lo[H] ? hi1[HW] : hi0[HW];
endmodule

// state | meaning
// IDLE  | o_ready=1, previous result held, waiting for a request
// RUN   | adding chunk k of the latched operands each edge
// DONE  | result valid, held until downstream accepts
module multiword_add_seq #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input logic                 i_clk,
    input logic                 i_rst,
    multiword_add_seq_if.slave  bus
);
    localparam int N  = WIDTH * WORDS;
    localparam int KW = $clog2(WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [N-1:0]     a_r;
    logic [N-1:0]     b_r;
    logic [N-1:0]     s_r;
    logic [N-1:0]     s_next;
    logic [KW-1:0]    k;
    logic             carry_r;
    logic             cout_r;
    logic             valid_r;
    logic             ready_r;
    logic [WIDTH-1:0] chunk_s;
    logic             chunk_c;

    multiword_add_seq_csel #(.W(WIDTH)) u_csel (
        .a    (a_r[k*WIDTH +: WIDTH]),
        .b    (b_r[k*WIDTH +: WIDTH]),
        .cin  (carry_r),
        .s    (chunk_s),
        .cout (chunk_c)
    );

    always_comb begin
        s_next = s_r;
        s_next[k*WIDTH +: WIDTH] = chunk_s;
    end

`ifdef MULTIWORD_ADD_SEQ_FLAGS_EN
    logic ovf_r;
    logic zero_r;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            k       <= '0;
            carry_r <= 1'b0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            s_r     <= '0;
            cout_r  <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
`ifdef MULTIWORD_ADD_SEQ_FLAGS_EN
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        a_r     <= bus.i_a;
                        b_r     <= bus.i_sub ? ~bus.i_b : bus.i_b;
                        carry_r <= bus.i_sub | bus.i_cin;
                        k       <= '0;
                        ready_r <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    s_r     <= s_next;
                    carry_r <= chunk_c;
                    k       <= k + KW'(1);
                    if (k == K_LAST) begin
                        k       <= '0;
                        cout_r  <= chunk_c;
                        valid_r <= 1'b1;
                        state   <= DONE;
`ifdef MULTIWORD_ADD_SEQ_FLAGS_EN
                        // s_next already holds the completed sum on this edge.
                        ovf_r  <= (a_r[N-1] == b_r[N-1]) && (s_next[N-1] != a_r[N-1]);
                        zero_r <= (s_next == '0);
`endif
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready = ready_r;
    assign bus.o_valid = valid_r;
    assign bus.o_s     = s_r;
    assign bus.o_cout  = cout_r;
`ifdef MULTIWORD_ADD_SEQ_FLAGS_EN
    assign bus.o_ovf   = ovf_r;
    assign bus.o_zero  = zero_r;
`else
    assign bus.o_ovf   = 1'b0;
    assign bus.o_zero  = 1'b0;
`endif
endmodule
